mdu_sched: RTL and testbench

- Sequencing controller and HI/LO holder for the multiply/divide resource used by the EX stage of the 5-stage pipeline.
- Accepts one operation at a time from EX and runs a fixed-latency countdown per operation class.
- Holds the result pending and commits it to HI/LO when the countdown ends; drives busy so the hazard unit stalls later HI/LO consumers.
- Gates new starts and HI/LO writes with the interrupt/flush signal. Operations already in flight always complete.

---
 rtl/mdu_sched.sv | 198 +++++++++++++++++++
 tb/tb_mdu_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sched
// Purpose  : Sequencing controller and HI/LO holder for the EX-stage
//            multiply/divide resource. Accepts one operation at a time, latches
//            the result as pending, counts down a fixed per-class latency and
//            then commits the pending value to HI/LO. busy tells the hazard
//            unit to stall later HI/LO consumers. flush suppresses new starts
//            and direct writes; an operation already running always completes.
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous active-high reset, clears all state
//            start  - request to begin operation 'op'
//            op     - 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6/7 no-op
//            write  - direct HI/LO write (mthi/mtlo)
//            addr   - write target: 1 = HI, 0 = LO
//            flush  - interrupt/exception; blocks same-cycle start and write
//            d1     - rs operand (also the direct-write data)
//            d2     - rt operand
//            busy   - operation in flight
//            hi, lo - HI and LO registers
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sched #(
  parameter int MULT_CYCLES = 5,   // busy length of mult/multu/madd/maddu, >= 1
  parameter int DIV_CYCLES  = 10   // busy length of div/divu, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        write,
  input  logic        addr,
  input  logic        flush,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MADD  = 3'd4;
  localparam logic [2:0] c_OP_MADDU = 3'd5;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;

  logic               w_busy;
  logic               w_done;
  logic               w_op_valid;
  logic               w_is_div;
  logic               w_start_ok;
  logic               w_write_ok;

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  assign w_op_valid = (op <= c_OP_MADDU);
  assign w_is_div   = (op == c_OP_DIV) || (op == c_OP_DIVU);
  assign w_start_ok = start && !flush && w_op_valid && (r_state == S_IDLE);
  // A qualified start takes priority over a same-cycle write.
  assign w_write_ok = write && !flush && (r_state == S_IDLE) && !w_start_ok;

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  logic [63:0]        w_acc;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_zero;
  logic [31:0]        w_mag1;
  logic [31:0]        w_mag2;
  logic [31:0]        w_qmag;
  logic [31:0]        w_rmag;
  logic [31:0]        w_q_s;
  logic [31:0]        w_r_s;
  logic [31:0]        w_divisor_u;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;
  logic [63:0]        w_res;

  assign w_acc    = {r_hi, r_lo};
  assign w_prod_s = $signed({{32{d1[31]}}, d1}) * $signed({{32{d2[31]}}, d2});
  assign w_prod_u = {32'b0, d1} * {32'b0, d2};

  // Signed divide runs on magnitudes so that 0x80000000 / -1 needs no special
  // case: the magnitude quotient 0x80000000 negates back to itself. A zero
  // divisor is replaced by 1 only to keep the dividers well defined; the
  // result is discarded in that case.
  assign w_div_zero  = (d2 == 32'd0);
  assign w_mag1      = d1[31] ? -d1 : d1;
  assign w_mag2      = w_div_zero ? 32'd1 : (d2[31] ? -d2 : d2);
  assign w_qmag      = w_mag1 / w_mag2;
  assign w_rmag      = w_mag1 % w_mag2;
  assign w_q_s       = (d1[31] ^ d2[31]) ? -w_qmag : w_qmag;
  assign w_r_s       = d1[31] ? -w_rmag : w_rmag;   // remainder follows dividend
  assign w_divisor_u = w_div_zero ? 32'd1 : d2;
  assign w_q_u       = d1 / w_divisor_u;
  assign w_r_u       = d1 % w_divisor_u;

  always_comb begin
    w_res = w_acc;  // divide-by-zero and no-ops leave HI/LO unchanged
    case (op)
      c_OP_MULT:  w_res = w_prod_s;
      c_OP_MULTU: w_res = w_prod_u;
      c_OP_DIV:   if (!w_div_zero) w_res = {w_r_s, w_q_s};
      c_OP_DIVU:  if (!w_div_zero) w_res = {w_r_u, w_q_u};
      c_OP_MADD:  w_res = w_acc + w_prod_s;
      c_OP_MADDU: w_res = w_acc + w_prod_u;
      default:    w_res = w_acc;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_next = S_RUN;
      S_RUN:   if (r_count == c_CNT_ONE) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    if (r_state == S_RUN) begin
      w_busy = 1'b1;
      w_done = (r_count == c_CNT_ONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: countdown, pending result, HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      if (w_start_ok) begin
        // madd/maddu sample HI/LO here, at the start edge.
        r_pend_hi <= w_res[63:32];
        r_pend_lo <= w_res[31:0];
        r_count   <= w_is_div ? c_DIV_CNT : c_MULT_CNT;
      end else if (r_state == S_RUN) begin
        r_count <= r_count - c_CNT_ONE;
        if (w_done) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else if (w_write_ok) begin
        if (addr) begin
          r_hi <= d1;
        end else begin
          r_lo <= d1;
        end
      end
    end
  end

  assign busy = w_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sched
// Purpose  : Self-checking bench for mdu_sched. Directed steps followed by
//            randomized operations, all compared against an arithmetic
//            reference model of HI/LO and of the busy length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

  localparam int MULT = 5;
  localparam int DIV  = 10;
  localparam int LIMIT = 40;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        write;
  logic        addr;
  logic        flush;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_sched #(
    .MULT_CYCLES(MULT),
    .DIV_CYCLES (DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .write(write),
    .addr (addr),
    .flush(flush),
    .d1   (d1),
    .d2   (d2),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {hi,lo} after an operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] acc;
    acc = {h, l};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(a) * 64'(b);
      3'd2: begin
        if (b == 32'd0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return acc;
        return {a % b, a / b};
      end
      3'd4: return acc + 64'(sa * sb);
      3'd5: return acc + 64'(a) * 64'(b);
      default: return acc;
    endcase
  endfunction

  function automatic int ref_len(input logic [2:0] o);
    if (o > 3'd5) return 0;
    if (o == 3'd2 || o == 3'd3) return DIV;
    return MULT;
  endfunction

  // Issue one start (called at a negedge) and follow it to completion.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [63:0] exp;
    int n;
    exp   = ref_result(o, a, b, m_hi, m_lo);
    op    = o;
    d1    = a;
    d2    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 64'(n), 64'(ref_len(o)));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic do_write(input logic sel, input logic [31:0] v, input logic fl,
                          input string tag);
    write = 1'b1;
    addr  = sel;
    d1    = v;
    flush = fl;
    @(negedge clk);
    write = 1'b0;
    flush = 1'b0;
    if (!fl) begin
      if (sel) m_hi = v;
      else     m_lo = v;
    end
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    int n;
    logic [2:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    write = 1'b0;
    addr  = 1'b0;
    flush = 1'b0;
    d1    = 32'd0;
    d2    = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;

    // Reset state
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Signed multiply
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
    check("mult_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    check("mult_idle", 64'(busy), 64'd0);

    // Signed divide, then divide by zero
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div");
    check("div_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    do_op(3'd3, 32'd7, 32'd0, "divu_zero");

    // Overflow corner of signed divide
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    check("div_ovf_hi_const", 64'(hi), 64'd0);

    // Write gating
    do_write(1'b1, 32'h1234, 1'b1, "wr_flushed");
    do_write(1'b1, 32'h1234, 1'b0, "wr_hi");
    check("wr_hi_const", 64'(hi), 64'h1234);

    // Start suppressed by flush
    op = 3'd0; d1 = 32'd2; d2 = 32'd2; flush = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flushed_busy", 64'(busy), 64'd0);
    check("start_flushed_hi", 64'(hi), 64'(m_hi));

    // maddu carry into HI
    do_write(1'b1, 32'd0, 1'b0, "set_hi");
    do_write(1'b0, 32'hFFFF_FFFF, 1'b0, "set_lo");
    do_op(3'd5, 32'd1, 32'd1, "maddu");
    check("maddu_hi_const", 64'(hi), 64'd1);
    check("maddu_lo_const", 64'(lo), 64'd0);

    // In-flight: flush + second start, then a write, during a multiply
    begin
      logic [63:0] exp;
      exp = ref_result(3'd0, 32'd5, 32'd7, m_hi, m_lo);
      op = 3'd0; d1 = 32'd5; d2 = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < LIMIT) begin
        n++;
        if (n == 1) begin
          flush = 1'b1; start = 1'b1; op = 3'd3; d1 = 32'd9; d2 = 32'd2;
        end else if (n == 2) begin
          flush = 1'b0; start = 1'b0; write = 1'b1; addr = 1'b0; d1 = 32'hDEAD;
        end else begin
          write = 1'b0;
        end
        @(negedge clk);
      end
      write = 1'b0;
      check("inflight_busy_len", 64'(n), 64'(MULT));
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      check("inflight_hi", 64'(hi), 64'(m_hi));
      check("inflight_lo", 64'(lo), 64'(m_lo));
      @(negedge clk);
      check("inflight_second_ignored", 64'(busy), 64'd0);
    end

    // Asynchronous reset in the middle of a divide
    op = 3'd2; d1 = 32'd100; d2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_after_rst");

    // Randomized operations and writes
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) < 2) begin
        do_write(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), "rnd_write");
      end else begin
        ro = 3'($urandom_range(0, 7));
        do_op(ro, ra, rb, "rnd_op");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
